dmem_req_ctrl: RTL and testbench

- Processor-side initiator for the tagged memory bus (addr/data/command out; response/data/tag in).
- Sits between the MEM stage and the data memory.
- Accepts one load or store per handshake, issues it on the bus, and retries if the request is rejected.
- For loads, holds the accepted tag and waits for the matching tag before returning the data to the pipeline. Stalls the pipeline until then.

---
 rtl/sys_defs.sv | 35 +++
 rtl/dmem_timeout_cnt.sv | 54 +++++
 rtl/dmem_req_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_dmem_req_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// ---------------------------------------------------------------------------
// sys_defs
//   Definitions shared by the processor, the data-memory request controller
//   and the memory model: bus command encodings and the controller state
//   type.
// ---------------------------------------------------------------------------
package sys_defs;

  // Bus command encodings carried on proc2mem_command.
  typedef logic [1:0] bus_cmd_t;

  localparam bus_cmd_t BUS_NONE  = 2'h0;
  localparam bus_cmd_t BUS_LOAD  = 2'h1;
  localparam bus_cmd_t BUS_STORE = 2'h2;

  // Request controller states.
  //   IDLE  : ready for a request from the MEM stage
  //   ISSUE : command on the bus, waiting for a nonzero response
  //   WAIT  : load accepted, waiting for its tag to come back
  //   DONE  : one-cycle completion
  //   ERR   : timeout trap, left only through reset
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } dmem_state_t;

  // True for the two commands the controller acts on.
  function automatic logic is_mem_cmd(input bus_cmd_t cmd);
    return (cmd == BUS_LOAD) || (cmd == BUS_STORE);
  endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// ---------------------------------------------------------------------------
// dmem_timeout_cnt
//   Counts the cycles a transaction spends on the bus. It flags expiry in the
//   cycle that would be the TIMEOUT-th counted cycle, so the controller
//   leaves for its error state after exactly TIMEOUT cycles in ISSUE/WAIT.
//
// Ports
//   clk     : clock, all updates on posedge
//   rst     : synchronous active-high reset
//   clr     : clear the count (takes priority over en)
//   en      : count this cycle
//   expired : high when en is set and this is the TIMEOUT-th counted cycle
// ---------------------------------------------------------------------------
module dmem_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MAX  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The count holds at TIMEOUT instead of wrapping, so a stuck enable can
  // never make the counter look young again.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q is the number of cycles already spent, so the cycle that sees
  // TIMEOUT-1 is the last one allowed.
  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/dmem_req_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_req_ctrl
//   Processor-side initiator for the tagged memory bus. It accepts one load
//   or store from the MEM stage, puts it on the bus, repeats it until the
//   memory accepts it, and for loads waits for the matching tag before
//   handing the data back. The pipeline is stalled for the whole
//   transaction. A transaction stuck on the bus for TIMEOUT cycles parks the
//   controller in an error state until reset.
//
// Handshake
//   A request is taken in a cycle where req_valid and req_ready are both
//   high and req_cmd is BUS_LOAD or BUS_STORE; the MEM stage must hold its
//   request stable while stall is high. Completion is a single-cycle
//   resp_valid pulse with load data on resp_rdata (0 for stores). On the bus
//   side a command is held on proc2mem_* until mem2proc_response is nonzero
//   in the same cycle; load data is taken in the cycle mem2proc_tag equals
//   the saved response tag.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/cmd/addr/wdata, req_ready : request from the MEM stage
//   resp_valid, resp_rdata              : completion back to the pipeline
//   stall              : hold MEM and older stages
//   timeout_err        : sticky timeout flag
//   proc2mem_addr/data/command          : bus request
//   mem2proc_response/data/tag          : bus acceptance and load return
//   dbg_state          : current controller state
// ---------------------------------------------------------------------------
module dmem_req_ctrl
  import sys_defs::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req_valid,
  input  logic [1:0]        req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,

  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              stall,
  output logic              timeout_err,

  output logic [ADDR_W-1:0] proc2mem_addr,
  output logic [DATA_W-1:0] proc2mem_data,
  output logic [1:0]        proc2mem_command,
  input  logic [TAG_W-1:0]  mem2proc_response,
  input  logic [DATA_W-1:0] mem2proc_data,
  input  logic [TAG_W-1:0]  mem2proc_tag,

  output dmem_state_t       dbg_state
);

  dmem_state_t       state_q, state_d;
  bus_cmd_t          cmd_q,   cmd_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TAG_W-1:0]  tag_q,   tag_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              terr_q,  terr_d;

  logic accept;
  logic accepted_on_bus;
  logic tag_hit;
  logic cnt_clr;
  logic cnt_en;
  logic expired;

  // -------------------------------------------------------------------------
  // Timeout counter: idles at zero in IDLE, so it starts from zero on every
  // entry to ISSUE, and counts every cycle spent in ISSUE or WAIT.
  // -------------------------------------------------------------------------
  assign cnt_clr = (state_q == IDLE);
  assign cnt_en  = (state_q == ISSUE) || (state_q == WAIT);

  dmem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  assign accept          = (state_q == IDLE) && req_valid && is_mem_cmd(req_cmd);
  assign accepted_on_bus = (mem2proc_response != '0);
  // tag_q is never zero in WAIT, but the explicit check keeps tag 0 meaning
  // "no transaction" even if that ever changes.
  assign tag_hit         = (tag_q != '0) && (mem2proc_tag == tag_q);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tag_d   = tag_q;
    rdata_d = rdata_q;
    terr_d  = terr_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_d   = req_cmd;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          tag_d   = '0;
          // Stores report zero data, so clear whatever the last load left.
          rdata_d = '0;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        // A response in the expiry cycle still counts as acceptance.
        if (accepted_on_bus) begin
          if (cmd_q == BUS_STORE) begin
            state_d = DONE;
          end else begin
            tag_d   = mem2proc_response;
            state_d = WAIT;
          end
        end else if (expired) begin
          terr_d  = 1'b1;
          state_d = ERR;
        end
      end

      WAIT: begin
        // Other tags belong to someone else and are ignored.
        if (tag_hit) begin
          rdata_d = mem2proc_data;
          state_d = DONE;
        end else if (expired) begin
          terr_d  = 1'b1;
          state_d = ERR;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      ERR: begin
        state_d = ERR;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= BUS_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
      rdata_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tag_q   <= tag_d;
      rdata_q <= rdata_d;
      terr_q  <= terr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    req_ready        = 1'b0;
    stall            = 1'b0;
    proc2mem_command = BUS_NONE;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        // Stall in the acceptance cycle so the MEM stage holds still while
        // the request is being latched.
        stall     = accept;
      end
      ISSUE: begin
        stall            = 1'b1;
        proc2mem_command = cmd_q;
      end
      WAIT: begin
        stall = 1'b1;
      end
      DONE: begin
        stall = 1'b0;
      end
      ERR: begin
        stall = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  assign resp_valid    = (state_q == DONE);
  assign resp_rdata    = rdata_q;
  assign timeout_err   = terr_q;
  assign proc2mem_addr = addr_q;
  assign proc2mem_data = wdata_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
module tb_dmem_req_ctrl;
  import sys_defs::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 8;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------
  logic              req_valid;
  logic [1:0]        req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              stall;
  logic              timeout_err;
  logic [ADDR_W-1:0] proc2mem_addr;
  logic [DATA_W-1:0] proc2mem_data;
  logic [1:0]        proc2mem_command;
  logic [TAG_W-1:0]  mem2proc_response;
  logic [DATA_W-1:0] mem2proc_data;
  logic [TAG_W-1:0]  mem2proc_tag;
  dmem_state_t       dbg_state;

  dmem_req_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_cmd           (req_cmd),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_ready         (req_ready),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .stall             (stall),
    .timeout_err       (timeout_err),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .proc2mem_command  (proc2mem_command),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag),
    .dbg_state         (dbg_state)
  );

  // ---------------------------------------------------------------------
  // Scoreboard counters and helpers
  // ---------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  // Advance to 1 time unit after the next rising edge; inputs driven after
  // this apply to the new cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_state"},       64'(dbg_state),        64'(IDLE));
    chk({pfx, "_req_ready"},   64'(req_ready),        64'(1));
    chk({pfx, "_resp_valid"},  64'(resp_valid),       64'(0));
    chk({pfx, "_resp_rdata"},  64'(resp_rdata),       64'(0));
    chk({pfx, "_stall"},       64'(stall),            64'(0));
    chk({pfx, "_timeout_err"}, 64'(timeout_err),      64'(0));
    chk({pfx, "_command"},     64'(proc2mem_command), 64'(BUS_NONE));
    chk({pfx, "_addr"},        64'(proc2mem_addr),    64'(0));
    chk({pfx, "_data"},        64'(proc2mem_data),    64'(0));
  endtask

  // ---------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------
  initial begin
    rst               = 1'b1;
    req_valid         = 1'b0;
    req_cmd           = BUS_NONE;
    req_addr          = '0;
    req_wdata         = '0;
    mem2proc_response = '0;
    mem2proc_data     = '0;
    mem2proc_tag      = '0;

    // ---- reset state ----
    cyc();
    cyc();
    check_reset_values("rst");

    // ---- ignored command: no stall, stays IDLE ----
    cyc();
    rst       = 1'b0;
    req_valid = 1'b1;
    req_cmd   = 2'h3;
    req_addr  = 32'h0000_0AAA;
    #1;
    chk("badcmd_stall", 64'(stall), 64'(0));
    cyc();
    req_valid = 1'b0;
    req_cmd   = BUS_NONE;
    #1;
    chk("badcmd_state", 64'(dbg_state), 64'(IDLE));
    chk("badcmd_cmd",   64'(proc2mem_command), 64'(BUS_NONE));

    // ---- load, latency 3, tag 1 ----
    // A: acceptance cycle
    cyc();
    req_valid = 1'b1;
    req_cmd   = BUS_LOAD;
    req_addr  = 32'h0000_0100;
    #1;
    chk("ld_acc_ready", 64'(req_ready), 64'(1));
    chk("ld_acc_stall", 64'(stall),     64'(1));
    // A+1: ISSUE, memory accepts with tag 1
    cyc();
    req_valid         = 1'b0;
    req_cmd           = BUS_NONE;
    mem2proc_response = 4'h1;
    #1;
    chk("ld_iss_cmd",   64'(proc2mem_command), 64'(BUS_LOAD));
    chk("ld_iss_addr",  64'(proc2mem_addr),    64'(32'h100));
    chk("ld_iss_stall", 64'(stall),            64'(1));
    chk("ld_iss_ready", 64'(req_ready),        64'(0));
    // A+2, A+3: WAIT
    cyc();
    mem2proc_response = '0;
    #1;
    chk("ld_w1_cmd",   64'(proc2mem_command), 64'(BUS_NONE));
    chk("ld_w1_stall", 64'(stall),            64'(1));
    cyc();
    #1;
    chk("ld_w2_stall", 64'(stall),      64'(1));
    chk("ld_w2_rv",    64'(resp_valid), 64'(0));
    // A+4: tag returns
    cyc();
    mem2proc_tag  = 4'h1;
    mem2proc_data = 32'hDEAD_BEEF;
    #1;
    chk("ld_w3_stall", 64'(stall),      64'(1));
    chk("ld_w3_rv",    64'(resp_valid), 64'(0));
    // A+5: DONE
    cyc();
    mem2proc_tag  = '0;
    mem2proc_data = '0;
    #1;
    chk("ld_done_rv",    64'(resp_valid), 64'(1));
    chk("ld_done_rdata", 64'(resp_rdata), 64'(32'hDEAD_BEEF));
    chk("ld_done_stall", 64'(stall),      64'(0));
    chk("ld_done_ready", 64'(req_ready),  64'(0));
    // A+6: back to IDLE, pulse was one cycle
    cyc();
    #1;
    chk("ld_idle_rv",    64'(resp_valid), 64'(0));
    chk("ld_idle_ready", 64'(req_ready),  64'(1));

    // ---- store, accepted immediately ----
    cyc();
    req_valid = 1'b1;
    req_cmd   = BUS_STORE;
    req_addr  = 32'h0000_0200;
    req_wdata = 32'h1234_5678;
    #1;
    chk("st_acc_stall", 64'(stall), 64'(1));
    cyc();
    req_valid         = 1'b0;
    req_cmd           = BUS_NONE;
    mem2proc_response = 4'h2;
    #1;
    chk("st_iss_cmd",  64'(proc2mem_command), 64'(BUS_STORE));
    chk("st_iss_addr", 64'(proc2mem_addr),    64'(32'h200));
    chk("st_iss_data", 64'(proc2mem_data),    64'(32'h1234_5678));
    cyc();
    mem2proc_response = '0;
    #1;
    chk("st_done_rv",    64'(resp_valid),       64'(1));
    chk("st_done_rdata", 64'(resp_rdata),       64'(0));
    chk("st_done_cmd",   64'(proc2mem_command), 64'(BUS_NONE));
    cyc();
    #1;
    chk("st_idle_rv", 64'(resp_valid), 64'(0));

    // ---- load rejected 3 times, then tag 7; stray tag 6 ignored ----
    cyc();
    req_valid = 1'b1;
    req_cmd   = BUS_LOAD;
    req_addr  = 32'h0000_0300;
    #1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      req_valid         = 1'b0;
      req_cmd           = BUS_NONE;
      req_addr          = 32'hFFFF_FFFF;
      mem2proc_response = '0;
      #1;
      chk("rt_rej_cmd",  64'(proc2mem_command), 64'(BUS_LOAD));
      chk("rt_rej_addr", 64'(proc2mem_addr),    64'(32'h300));
    end
    cyc();
    mem2proc_response = 4'h7;
    #1;
    chk("rt_acc_cmd",  64'(proc2mem_command), 64'(BUS_LOAD));
    chk("rt_acc_addr", 64'(proc2mem_addr),    64'(32'h300));
    cyc();
    mem2proc_response = '0;
    mem2proc_tag      = 4'h6;
    mem2proc_data     = 32'h0BAD_0BAD;
    #1;
    chk("rt_w_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    cyc();
    mem2proc_tag  = 4'h7;
    mem2proc_data = 32'hCAFE_F00D;
    #1;
    chk("rt_stray_state", 64'(dbg_state),  64'(WAIT));
    chk("rt_stray_rv",    64'(resp_valid), 64'(0));
    cyc();
    mem2proc_tag  = '0;
    mem2proc_data = '0;
    #1;
    chk("rt_done_rv",    64'(resp_valid), 64'(1));
    chk("rt_done_rdata", 64'(resp_rdata), 64'(32'hCAFE_F00D));
    cyc();
    #1;

    // ---- timeout: no response for TIMEOUT cycles ----
    req_valid = 1'b1;
    req_cmd   = BUS_LOAD;
    req_addr  = 32'h0000_0400;
    #1;
    chk("to_acc_stall", 64'(stall), 64'(1));
    for (int i = 0; i < TIMEOUT; i++) begin
      cyc();
      req_valid = 1'b0;
      req_cmd   = BUS_NONE;
      #1;
      chk("to_iss_cmd",  64'(proc2mem_command), 64'(BUS_LOAD));
      chk("to_iss_terr", 64'(timeout_err),      64'(0));
    end
    cyc();
    req_valid = 1'b1;
    req_cmd   = BUS_STORE;
    #1;
    chk("to_err_terr",  64'(timeout_err),      64'(1));
    chk("to_err_state", 64'(dbg_state),        64'(ERR));
    chk("to_err_cmd",   64'(proc2mem_command), 64'(BUS_NONE));
    chk("to_err_stall", 64'(stall),            64'(1));
    chk("to_err_ready", 64'(req_ready),        64'(0));
    // A late response and tag do not pull it out of the trap.
    cyc();
    mem2proc_response = 4'h5;
    mem2proc_tag      = 4'h5;
    #1;
    chk("to_hold_terr",  64'(timeout_err), 64'(1));
    chk("to_hold_ready", 64'(req_ready),   64'(0));
    cyc();
    mem2proc_response = '0;
    mem2proc_tag      = '0;
    req_valid         = 1'b0;
    req_cmd           = BUS_NONE;
    rst               = 1'b1;
    #1;
    chk("to_hold2_terr", 64'(timeout_err), 64'(1));
    cyc();
    rst = 1'b0;
    #1;
    check_reset_values("to_rst");

    // ---- reset during WAIT, tag returns afterwards ----
    cyc();
    req_valid = 1'b1;
    req_cmd   = BUS_LOAD;
    req_addr  = 32'h0000_0600;
    #1;
    cyc();
    req_valid         = 1'b0;
    req_cmd           = BUS_NONE;
    mem2proc_response = 4'h3;
    #1;
    cyc();
    mem2proc_response = '0;
    rst               = 1'b1;
    #1;
    chk("rw_wait_state", 64'(dbg_state), 64'(WAIT));
    cyc();
    rst           = 1'b0;
    mem2proc_tag  = 4'h3;
    mem2proc_data = 32'h5555_AAAA;
    #1;
    chk("rw_idle_state", 64'(dbg_state),  64'(IDLE));
    chk("rw_idle_rv",    64'(resp_valid), 64'(0));
    cyc();
    mem2proc_tag  = '0;
    mem2proc_data = '0;
    #1;
    chk("rw_after_rv",    64'(resp_valid), 64'(0));
    chk("rw_after_rdata", 64'(resp_rdata), 64'(0));
    chk("rw_after_state", 64'(dbg_state),  64'(IDLE));

    // ---- back-to-back loads with req_valid held high ----
    // A: first accepted
    cyc();
    req_valid = 1'b1;
    req_cmd   = BUS_LOAD;
    req_addr  = 32'h0000_0500;
    #1;
    chk("bb1_acc_ready", 64'(req_ready), 64'(1));
    cyc();
    mem2proc_response = 4'h5;
    #1;
    chk("bb1_iss_ready", 64'(req_ready),     64'(0));
    chk("bb1_iss_addr",  64'(proc2mem_addr), 64'(32'h500));
    cyc();
    mem2proc_response = '0;
    mem2proc_tag      = 4'h5;
    mem2proc_data     = 32'h1111_1111;
    #1;
    chk("bb1_w_ready", 64'(req_ready), 64'(0));
    // DONE: request still presented, must not be taken again
    cyc();
    mem2proc_tag  = '0;
    mem2proc_data = '0;
    #1;
    chk("bb1_done_rv",    64'(resp_valid), 64'(1));
    chk("bb1_done_rdata", 64'(resp_rdata), 64'(32'h1111_1111));
    chk("bb1_done_ready", 64'(req_ready),  64'(0));
    chk("bb1_done_stall", 64'(stall),      64'(0));
    // Pipeline advanced: second request taken in the cycle after DONE
    cyc();
    req_addr = 32'h0000_0504;
    #1;
    chk("bb2_acc_ready", 64'(req_ready),  64'(1));
    chk("bb2_acc_stall", 64'(stall),      64'(1));
    chk("bb2_acc_rv",    64'(resp_valid), 64'(0));
    cyc();
    req_valid         = 1'b0;
    req_cmd           = BUS_NONE;
    mem2proc_response = 4'h9;
    #1;
    chk("bb2_iss_cmd",  64'(proc2mem_command), 64'(BUS_LOAD));
    chk("bb2_iss_addr", 64'(proc2mem_addr),    64'(32'h504));
    cyc();
    mem2proc_response = '0;
    mem2proc_tag      = 4'h9;
    mem2proc_data     = 32'h2222_2222;
    #1;
    chk("bb2_w_rv", 64'(resp_valid), 64'(0));
    cyc();
    mem2proc_tag  = '0;
    mem2proc_data = '0;
    #1;
    chk("bb2_done_rv",    64'(resp_valid), 64'(1));
    chk("bb2_done_rdata", 64'(resp_rdata), 64'(32'h2222_2222));
    cyc();
    #1;
    chk("bb2_idle_rv",    64'(resp_valid), 64'(0));
    chk("bb2_idle_state", 64'(dbg_state),  64'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
